// File: rtl/rv32i_core_mc.sv
// rv32i_core_mc: multi-cycle RV32I core (OP, OP-IMM, LUI) sequenced FETCH/DECODE/EXEC/WB, halting on illegal words.
// Optional macro RETIRE_CNT_EN adds a wrapping retired-instruction counter output retire_count.
module rv32i_core_mc #(
   parameter int          NREGS    = 32,
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        retire,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_data,
   output logic        halted,
   output logic        illegal,
`ifdef RETIRE_CNT_EN
   output logic [31:0] retire_count,
`endif
   input  logic [4:0]  dbg_raddr,
   output logic [31:0] dbg_rdata
);
   localparam int         AW        = $clog2(NREGS);
   localparam logic [5:0] NREGS_W   = 6'(NREGS);
   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

   state_t      state;
   logic [31:0] pc, instr, rs1_val, rs2_val, imm, result;
   logic [31:0] regs [NREGS];

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;
   logic        legal, alt;
   logic [31:0] imm_dec, op_b, alu_out;

   assign opcode = instr[6:0];
   assign rd     = instr[11:7];
   assign funct3 = instr[14:12];
   assign rs1    = instr[19:15];
   assign rs2    = instr[24:20];
   assign funct7 = instr[31:25];

   function automatic logic idx_ok(input logic [4:0] idx);
      return {1'b0, idx} < NREGS_W;
   endfunction

   always_comb begin
      legal = 1'b0;
      case (opcode)
         OPC_OP: legal = (funct7 == 7'b0000000 ||
                          (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                         && idx_ok(rs1) && idx_ok(rs2) && idx_ok(rd);
         OPC_OPIMM: begin
            case (funct3)
               3'b001:  legal = (funct7 == 7'b0000000);
               3'b101:  legal = (funct7 == 7'b0000000 || funct7 == 7'b0100000);
               default: legal = 1'b1;
            endcase
            legal = legal && idx_ok(rs1) && idx_ok(rd);
         end
         OPC_LUI: legal = idx_ok(rd);
         default: legal = 1'b0;
      endcase
   end

   assign imm_dec = (opcode == OPC_LUI) ? {instr[31:12], 12'b0} : {{20{instr[31]}}, instr[31:20]};

   // bit 30 selects SUB/SRA for OP, but only SRAI for OP-IMM (ADDI has no alternate form)
   always_comb begin
      op_b    = (opcode == OPC_OP) ? rs2_val : imm;
      alt     = instr[30] && (opcode == OPC_OP || funct3 == 3'b101);
      alu_out = '0;
      if (opcode == OPC_LUI) begin
         alu_out = imm;
      end else begin
         case (funct3)
            3'b000:  alu_out = alt ? rs1_val - op_b : rs1_val + op_b;
            3'b001:  alu_out = rs1_val << op_b[4:0];
            3'b010:  alu_out = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'b011:  alu_out = {31'b0, rs1_val < op_b};
            3'b100:  alu_out = rs1_val ^ op_b;
            3'b101:  alu_out = alt ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
            3'b110:  alu_out = rs1_val | op_b;
            default: alu_out = rs1_val & op_b;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= FETCH;
         pc          <= PC_RESET;
         instr       <= '0;
         rs1_val     <= '0;
         rs2_val     <= '0;
         imm         <= '0;
         result      <= '0;
         retire      <= 1'b0;
         retire_rd   <= '0;
         retire_data <= '0;
         halted      <= 1'b0;
         illegal     <= 1'b0;
      end else begin
         retire <= 1'b0;
         case (state)
            FETCH: if (imem_ack) begin
               instr <= imem_rdata;
               state <= DECODE;
            end
            DECODE: if (!legal) begin
               illegal <= 1'b1;
               halted  <= 1'b1;
               state   <= HALT;
            end else begin
               rs1_val <= regs[rs1[AW-1:0]];
               rs2_val <= regs[rs2[AW-1:0]];
               imm     <= imm_dec;
               state   <= EXEC;
            end
            EXEC: begin
               result      <= alu_out;
               retire      <= 1'b1;
               retire_rd   <= rd;
               retire_data <= alu_out;
               state       <= WB;
            end
            WB: begin
               pc    <= pc + 32'd4;
               state <= FETCH;
            end
            default: state <= HALT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (state == WB && rd != '0) begin
         regs[rd[AW-1:0]] <= result;
      end
   end

`ifdef RETIRE_CNT_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)           retire_count <= '0;
      else if (state == WB) retire_count <= retire_count + 32'd1;
   end
`endif

   assign imem_req  = reset && (state == FETCH);
   assign imem_addr = pc;
   assign dbg_rdata = (dbg_raddr != '0 && idx_ok(dbg_raddr)) ? regs[dbg_raddr[AW-1:0]] : '0;

endmodule
